gesummv_kernel: RTL and testbench

GESUMMV_KERNEL -- requirements
Module: gesummv_kernel

---
 rtl/gesummv_pkg.sv | 15 +
 rtl/gesummv_mac.sv | 25 ++
 rtl/gesummv_kernel.sv | 153 +++++++++++++++
 tb/tb_gesummv_kernel.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gesummv_pkg.sv
// Shared constants and FSM state encoding for the gesummv kernel.
package gesummv_pkg;

    localparam int N = 8;   // matrix / vector dimension
    localparam int W = 32;  // data width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/gesummv_mac.sv
// W-bit multiply-accumulate with synchronous clear; wraps modulo 2^W.
module gesummv_mac #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc
);

    // Accumulate a*b when enabled; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + a * b;
        end
    end

endmodule

// File: rtl/gesummv_kernel.sv
// gesummv: tmp = A*x, y = alpha*tmp + beta*(B*x), one row at a time.
// Memory handshake: rd_en at posedge k returns rd_data sampled at posedge
// k+1; wr_en is a single-cycle strobe with address/data valid alongside it.
// Enables are decoded from the state register, so an asynchronous reset
// drops every enable at once.
module gesummv_kernel #(
    parameter int N   = gesummv_pkg::N,
    parameter int W   = gesummv_pkg::W,
    parameter int AW  = $clog2(N),
    parameter int MAW = $clog2(N * N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tstart,
    input  logic [W-1:0]   v0,
    input  logic [W-1:0]   v1,
    output logic [AW-1:0]  v2_addr,
    output logic           v2_wr_en,
    output logic [W-1:0]   v2_wr_data,
    output logic [MAW-1:0] v3_addr,
    output logic           v3_rd_en,
    input  logic [W-1:0]   v3_rd_data,
    output logic [MAW-1:0] v4_addr,
    output logic           v4_rd_en,
    input  logic [W-1:0]   v4_rd_data,
    output logic [AW-1:0]  v5_addr,
    output logic           v5_rd_en,
    input  logic [W-1:0]   v5_rd_data,
    output logic [AW-1:0]  v6_addr,
    output logic           v6_wr_en,
    output logic [W-1:0]   v6_wr_data,
    output logic           done
);

    import gesummv_pkg::*;

    state_t         state;
    state_t         state_nxt;
    logic [AW-1:0]  row;
    logic [AW-1:0]  col;
    logic           rd_pend;   // a read was issued last cycle; its data is on rd_data now
    logic           last_col;
    logic           last_row;
    logic           mac_clr;
    logic [W-1:0]   acc_a;
    logic [W-1:0]   acc_b;
    logic [MAW-1:0] mat_addr;

    assign last_col = (col == AW'(N - 1));
    assign last_row = (row == AW'(N - 1));
    assign mat_addr = MAW'(row) * MAW'(N) + MAW'(col);
    assign mac_clr  = (state == ST_WRITE) || (state == ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; tstart is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (tstart) state_nxt = ST_READ;
            ST_READ:  if (last_col) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_row ? ST_DONE : ST_READ;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Row/column counters, read-pending flag and registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row     <= '0;
            col     <= '0;
            rd_pend <= 1'b0;
            done    <= 1'b0;
        end else begin
            rd_pend <= (state == ST_READ);
            done    <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (tstart) begin
                        row <= '0;
                        col <= '0;
                    end
                end
                ST_READ:  col <= last_col ? '0 : col + AW'(1);
                ST_WRITE: row <= last_row ? '0 : row + AW'(1);
                default: ;
            endcase
        end
    end

    // One x word feeds both products.
    gesummv_mac #(.W(W)) u_mac_a (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (rd_pend),
        .a   (v3_rd_data),
        .b   (v5_rd_data),
        .acc (acc_a)
    );

    gesummv_mac #(.W(W)) u_mac_b (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (rd_pend),
        .a   (v4_rd_data),
        .b   (v5_rd_data),
        .acc (acc_b)
    );

    // Memory-side outputs; everything idles at zero outside its active state.
    always_comb begin
        v3_rd_en   = 1'b0;
        v4_rd_en   = 1'b0;
        v5_rd_en   = 1'b0;
        v3_addr    = '0;
        v4_addr    = '0;
        v5_addr    = '0;
        v2_wr_en   = 1'b0;
        v6_wr_en   = 1'b0;
        v2_addr    = '0;
        v6_addr    = '0;
        v2_wr_data = '0;
        v6_wr_data = '0;
        if (state == ST_READ) begin
            v3_rd_en = 1'b1;
            v4_rd_en = 1'b1;
            v5_rd_en = 1'b1;
            v3_addr  = mat_addr;
            v4_addr  = mat_addr;
            v5_addr  = col;
        end
        if (state == ST_WRITE) begin
            v2_wr_en   = 1'b1;
            v6_wr_en   = 1'b1;
            v2_addr    = row;
            v6_addr    = row;
            v2_wr_data = acc_a;
            v6_wr_data = v0 * acc_a + v1 * acc_b;
        end
    end

endmodule

// File: tb/tb_gesummv_kernel.sv
// Bench for gesummv_kernel: memory models, behavioural gesummv model,
// per-cycle compare process and directed + random runs.
module tb_gesummv_kernel;

    localparam int N   = 8;
    localparam int W   = 32;
    localparam int AW  = 3;
    localparam int MAW = 6;

    typedef struct {
        logic [AW-1:0] row;
        logic [W-1:0]  tmp;
        logic [W-1:0]  y;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           tstart;
    logic [W-1:0]   v0;
    logic [W-1:0]   v1;
    logic [AW-1:0]  v2_addr;
    logic           v2_wr_en;
    logic [W-1:0]   v2_wr_data;
    logic [MAW-1:0] v3_addr;
    logic           v3_rd_en;
    logic [W-1:0]   v3_rd_data;
    logic [MAW-1:0] v4_addr;
    logic           v4_rd_en;
    logic [W-1:0]   v4_rd_data;
    logic [AW-1:0]  v5_addr;
    logic           v5_rd_en;
    logic [W-1:0]   v5_rd_data;
    logic [AW-1:0]  v6_addr;
    logic           v6_wr_en;
    logic [W-1:0]   v6_wr_data;
    logic           done;

    logic [W-1:0] mem_a [N*N];
    logic [W-1:0] mem_b [N*N];
    logic [W-1:0] mem_x [N];
    logic [W-1:0] m_tmp [N];
    logic [W-1:0] m_y   [N];

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   writes_seen;
    int   done_seen;

    gesummv_kernel #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .tstart     (tstart),
        .v0         (v0),
        .v1         (v1),
        .v2_addr    (v2_addr),
        .v2_wr_en   (v2_wr_en),
        .v2_wr_data (v2_wr_data),
        .v3_addr    (v3_addr),
        .v3_rd_en   (v3_rd_en),
        .v3_rd_data (v3_rd_data),
        .v4_addr    (v4_addr),
        .v4_rd_en   (v4_rd_en),
        .v4_rd_data (v4_rd_data),
        .v5_addr    (v5_addr),
        .v5_rd_en   (v5_rd_en),
        .v5_rd_data (v5_rd_data),
        .v6_addr    (v6_addr),
        .v6_wr_en   (v6_wr_en),
        .v6_wr_data (v6_wr_data),
        .done       (done)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memories; unrequested cycles return random garbage.
    always @(posedge clk) begin
        v3_rd_data <= v3_rd_en ? mem_a[v3_addr] : W'($urandom());
        v4_rd_data <= v4_rd_en ? mem_b[v4_addr] : W'($urandom());
        v5_rd_data <= v5_rd_en ? mem_x[v5_addr] : W'($urandom());
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain matrix-vector arithmetic, wrapping at 32 bits.
    task automatic build_model(input logic [W-1:0] alpha, input logic [W-1:0] beta);
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            sa = '0;
            sb = '0;
            for (int j = 0; j < N; j++) begin
                sa = sa + mem_a[i*N+j] * mem_x[j];
                sb = sb + mem_b[i*N+j] * mem_x[j];
            end
            m_tmp[i] = sa;
            m_y[i]   = alpha * sa + beta * sb;
            e.row = AW'(i);
            e.tmp = m_tmp[i];
            e.y   = m_y[i];
            exp_q.push_back(e);
        end
        v0 = alpha;
        v1 = beta;
    endtask

    // Per-cycle compare: bus rules every cycle, write contents against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic ok;
            exp_t e;
            ok = (v3_rd_en == v4_rd_en) && (v3_rd_en == v5_rd_en) && (v2_wr_en == v6_wr_en)
                 && !(v3_rd_en && v2_wr_en)
                 && (v3_rd_en || (v3_addr == 0 && v4_addr == 0 && v5_addr == 0))
                 && (v2_wr_en || (v2_addr == 0 && v6_addr == 0 && v2_wr_data == 0 && v6_wr_data == 0));
            check("bus_rules", W'(ok), W'(1));
            if (v2_wr_en) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", W'(1), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("tmp_addr", W'(v2_addr), W'(e.row));
                    check("y_addr", W'(v6_addr), W'(e.row));
                    check("tmp_data", v2_wr_data, e.tmp);
                    check("y_data", v6_wr_data, e.y);
                end
            end
            if (done) done_seen++;
        end
    end

    // Start a run; optional ignored tstart at cycle mid, optional reset at cycle abort_at.
    task automatic run_kernel(input int mid, input int abort_at, output int cycles);
        writes_seen = 0;
        done_seen   = 0;
        @(posedge clk);
        #2 tstart = 1'b1;
        @(posedge clk);
        cycles = 0;
        #2 tstart = 1'b0;
        while (cycles < 200) begin
            @(posedge clk);
            cycles++;
            #2 tstart = (cycles == mid);
            if (abort_at != 0 && cycles == abort_at) begin
                rst = 1'b1;
                return;
            end
            if (done) break;
        end
    endtask

    task automatic finish_run(input int cycles);
        check("done_latency", W'(cycles), W'(81));
        @(posedge clk);
        #2 check("done_width", W'(done), W'(0));
        check("writes_left", W'(exp_q.size()), W'(0));
        check("write_count", W'(writes_seen), W'(N));
        check("done_count", W'(done_seen), W'(1));
    endtask

    task automatic load_nominal();
        for (int k = 0; k < N*N; k++) begin
            mem_a[k] = W'(k + 1);
            mem_b[k] = W'(k + 1);
        end
        for (int j = 0; j < N; j++) mem_x[j] = W'(j + 1);
    endtask

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        writes_seen = 0;
        done_seen = 0;
        rst = 1'b1;
        tstart = 1'b0;
        v0 = '0;
        v1 = '0;
        load_nominal();

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_rd_en", W'({v3_rd_en, v4_rd_en, v5_rd_en}), W'(0));
        check("rst_wr_en", W'({v2_wr_en, v6_wr_en}), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_addr", W'({v2_addr, v3_addr, v4_addr, v5_addr, v6_addr}), W'(0));
        rst = 1'b0;

        // Nominal data.
        build_model(32'd1, 32'd1);
        check("pin_tmp0", m_tmp[0], 32'd204);
        check("pin_tmp7", m_tmp[7], 32'd2220);
        check("pin_y0", m_y[0], 32'd408);
        check("pin_y7", m_y[7], 32'd4440);
        run_kernel(0, 0, cyc);
        finish_run(cyc);

        // alpha=2, beta=0.
        build_model(32'd2, 32'd0);
        check("pin_a2_y3", m_y[3], 32'd2136);
        check("pin_a2_tmp3", m_tmp[3], 32'd1068);
        run_kernel(0, 0, cyc);
        finish_run(cyc);

        // Identity A, zero B.
        for (int k = 0; k < N*N; k++) begin
            mem_a[k] = (k / N == k % N) ? 32'd1 : 32'd0;
            mem_b[k] = '0;
        end
        build_model(32'd3, 32'd5);
        check("pin_id_tmp5", m_tmp[5], 32'd6);
        check("pin_id_y5", m_y[5], 32'd18);
        run_kernel(0, 0, cyc);
        finish_run(cyc);

        // Overflow wraps.
        for (int k = 0; k < N*N; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
        end
        for (int j = 0; j < N; j++) mem_x[j] = '0;
        mem_a[0] = 32'h8000_0000;
        mem_b[0] = 32'h8000_0000;
        mem_x[0] = 32'd2;
        build_model(32'd1, 32'd1);
        check("pin_ovf_tmp0", m_tmp[0], 32'd0);
        check("pin_ovf_y0", m_y[0], 32'd0);
        run_kernel(0, 0, cyc);
        finish_run(cyc);

        // Reset during row 3, then a clean run.
        load_nominal();
        build_model(32'd1, 32'd1);
        run_kernel(0, 35, cyc);
        #1;
        check("abort_rd_en", W'({v3_rd_en, v4_rd_en, v5_rd_en}), W'(0));
        check("abort_wr_en", W'({v2_wr_en, v6_wr_en}), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_writes", W'(writes_seen), W'(3));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        #2 check("abort_no_done", W'(done_seen), W'(0));
        check("abort_no_writes", W'(writes_seen), W'(3));
        build_model(32'd1, 32'd1);
        run_kernel(0, 0, cyc);
        finish_run(cyc);

        // tstart mid-run is ignored.
        build_model(32'd7, 32'd3);
        run_kernel(40, 0, cyc);
        finish_run(cyc);

        // Random matrices, vectors and scalars.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N*N; k++) begin
                mem_a[k] = W'($urandom());
                mem_b[k] = (r == 0) ? W'($urandom_range(0, 15)) : W'($urandom());
            end
            for (int j = 0; j < N; j++) mem_x[j] = W'($urandom());
            build_model(W'($urandom()), W'($urandom()));
            run_kernel(0, 0, cyc);
            finish_run(cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
